// File: rtl/vga_timing_controller.sv
// vga_timing_controller
//
// Raster timing for a 640x480@60 Hz VGA display. A clock divider produces the
// pixel rate; horizontal/vertical counters walk the 800x525 raster. The counters
// drive the graphics generator. Its colour comes back on pixelColor and is
// registered, blanked outside the visible area, and aligned with hsync/vsync.
//
// Optional build macro: VGA_TEST_PATTERN_EN
//   When defined, the testPatternSel input is added. With testPatternSel=1 the
//   visible colour is eight 80-pixel vertical colour bars instead of pixelColor.
//
// Ports:
//   clk            in   system clock (100 MHz)
//   rst_n          in   asynchronous active-low reset
//   pixelColor     in   {R,G,B} 4 bits each for the current counters
//   testPatternSel in   colour-bar select (only with VGA_TEST_PATTERN_EN)
//   horizCount     out  current pixel column, 0..H_TOTAL-1
//   vertCount      out  current line, 0..V_TOTAL-1
//   pixelTick      out  one-clk pulse on the cycle the counters advance
//   displayActive  out  counters are inside the visible area (combinational)
//   frameStart     out  one-clk pulse as the counters wrap to (0,0)
//   hsync, vsync   out  active-low syncs, registered
//   vgaRed/Green/Blue out registered, blanked colour
module vga_timing_controller #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] pixelColor,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        testPatternSel,
`endif
  output logic [9:0]  horizCount,
  output logic [9:0]  vertCount,
  output logic        pixelTick,
  output logic        displayActive,
  output logic        frameStart,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vgaRed,
  output logic [3:0]  vgaGreen,
  output logic [3:0]  vgaBlue
);

  localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [9:0] HLast   = 10'(HTotal - 1);
  localparam logic [9:0] VLast   = 10'(VTotal - 1);
  localparam logic [9:0] HVis    = 10'(H_VISIBLE);
  localparam logic [9:0] VVis    = 10'(V_VISIBLE);
  localparam logic [9:0] HsFirst = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HsLast  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VsFirst = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VsLast  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DivW-1:0] div_q, div_d;
  logic            tick_q, tick_d;
  logic [9:0]      h_q, h_d;
  logic [9:0]      v_q, v_d;
  logic            frame_q, frame_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic [11:0]     rgb_q, rgb_d;
  logic            active;
  logic [11:0]     colour_src;

`ifdef VGA_TEST_PATTERN_EN
  // Bar index = column / 80, built from compares rather than a divider.
  function automatic logic [11:0] bar_colour(logic [9:0] h);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h >= 10'(80 * k)) idx = 3'(k);
    end
    return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
  endfunction

  assign colour_src = testPatternSel ? bar_colour(h_q) : pixelColor;
`else
  assign colour_src = pixelColor;
`endif

  assign active = (h_q < HVis) && (v_q < VVis);

  always_comb begin
    div_d   = (div_q == DivLast) ? '0 : div_q + 1'b1;
    // Registered tick is high exactly while the divider sits at its last value.
    tick_d  = (div_d == DivLast);
    h_d     = h_q;
    v_d     = v_q;
    frame_d = 1'b0;
    hs_d    = hs_q;
    vs_d    = vs_q;
    rgb_d   = rgb_q;
    if (tick_q) begin
      if (h_q == HLast) begin
        h_d = '0;
        if (v_q == VLast) begin
          v_d     = '0;
          frame_d = 1'b1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
      // Output stage samples the pre-advance position: one pixel of latency.
      hs_d  = !((h_q >= HsFirst) && (h_q <= HsLast));
      vs_d  = !((v_q >= VsFirst) && (v_q <= VsLast));
      rgb_d = active ? colour_src : 12'h000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      rgb_q   <= 12'h000;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      rgb_q   <= rgb_d;
    end
  end

  assign horizCount    = h_q;
  assign vertCount     = v_q;
  assign pixelTick     = tick_q;
  assign displayActive = active;
  assign frameStart    = frame_q;
  assign hsync         = hs_q;
  assign vsync         = vs_q;
  assign vgaRed        = rgb_q[11:8];
  assign vgaGreen      = rgb_q[7:4];
  assign vgaBlue       = rgb_q[3:0];

endmodule
